// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: boot-loads instruction memory from a word stream, then
// drives stallF/enF/flushF from decode hazards, branch redirects and halt/resume.
module fetch_ctrl #(
    parameter int IMEM_POWER = 18,
    parameter int WORD       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [WORD-1:0]       load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  imem_we,
    output logic [IMEM_POWER-1:0] imem_waddr,
    output logic [WORD-1:0]       imem_wdata,
    input  logic                  stall_req,
    input  logic                  PCSrcD,
    input  logic                  halt_req,
    input  logic                  resume_req,
    output logic                  stallF,
    output logic                  enF,
    output logic                  flushF,
    output logic                  running,
    output logic                  load_err,
    output logic [IMEM_POWER:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        HALT,
        ERR
    } state_t;

    state_t                state_q, state_d;
    logic [IMEM_POWER:0]   count_q, count_d;
    logic                  full;
    logic                  accept;

    // The count tops out at exactly 2**IMEM_POWER, so its MSB alone marks a full image.
    assign full = count_q[IMEM_POWER];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        load_ready = 1'b0;
        accept     = 1'b0;
        stallF     = 1'b1;
        enF        = 1'b0;
        flushF     = 1'b1;
        case (state_q)
            IDLE, LOAD: begin
                load_ready = !full;
                if (load_valid) begin
                    if (full) begin
                        state_d = ERR;
                    end else begin
                        accept  = 1'b1;
                        count_d = count_q + (IMEM_POWER+1)'(1);
                        state_d = load_last ? START : LOAD;
                    end
                end
            end
            START: begin
                state_d = RUN;
            end
            RUN: begin
                // A pending hazard holds the fetch register, so a redirect flush waits for it.
                stallF = stall_req;
                enF    = !stall_req;
                flushF = PCSrcD & !stall_req;
                if (halt_req) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                flushF = 1'b0;
                if (resume_req && !halt_req) begin
                    state_d = RUN;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write strobe is suppressed while reset is held so no store lands during reset.
    assign imem_we      = accept & !reset;
    assign imem_waddr   = count_q[IMEM_POWER-1:0];
    assign imem_wdata   = load_data;
    assign running      = (state_q == RUN);
    assign load_err     = (state_q == ERR);
    assign words_loaded = count_q;

endmodule
